// File: rtl/basic_computer_pkg.sv
// Shared control-unit constants: default timing-state count and SC update priority encoding.
package basic_computer_pkg;

   localparam int T_NUM_DEFAULT = 16;

   localparam logic [1:0] SC_OP_CLR  = 2'd0;
   localparam logic [1:0] SC_OP_LD   = 2'd1;
   localparam logic [1:0] SC_OP_INR  = 2'd2;
   localparam logic [1:0] SC_OP_HOLD = 2'd3;

   // An illegal load resolves to HOLD so it can never fall through to the increment.
   function automatic logic [1:0] sc_op_sel(input logic clr, input logic ld, input logic ld_ok,
                                            input logic inr, input logic halt);
      if (clr)
         return SC_OP_CLR;
      if (ld)
         return ld_ok ? SC_OP_LD : SC_OP_HOLD;
      if (inr && !halt)
         return SC_OP_INR;
      return SC_OP_HOLD;
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational binary-to-one-hot decoder; inputs at or above OUT_N give all zeros.
module onehot_decoder #(
   parameter int IN_W  = 4,
   parameter int OUT_N = 16
) (
   input  logic [IN_W-1:0]  in_dat,
   output logic [OUT_N-1:0] out_dat
);

   always_comb begin
      out_dat = '0;
      for (int i = 0; i < OUT_N; i++) begin
         out_dat[i] = (32'(in_dat) == 32'(i));
      end
   end

endmodule

// File: rtl/timing_sequencer.sv
// Sequence counter with one-hot timing decode; clear > load > increment priority, halt freezes increment only.
module timing_sequencer
   import basic_computer_pkg::*;
#(
   parameter int  NUM_T = T_NUM_DEFAULT,
   localparam int SC_W  = $clog2(NUM_T)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sc_clr,
   input  logic             sc_ld,
   input  logic [SC_W-1:0]  sc_ld_val,
   input  logic             sc_inr,
   input  logic             halt,
   output logic [SC_W-1:0]  sc,
   output logic [NUM_T-1:0] t,
   output logic             t_last,
   output logic             t_wrap,
   output logic             ld_err
);

   localparam logic [SC_W-1:0] SC_LAST = SC_W'(NUM_T - 1);

   logic [SC_W-1:0] sc_q, sc_d;
   logic            t_wrap_q, t_wrap_d;
   logic            ld_err_q, ld_err_d;
   logic [1:0]      sc_op;
   logic            ld_ok;
   logic            at_last;

   assign at_last = (sc_q == SC_LAST);
   assign ld_ok   = (32'(sc_ld_val) < 32'(NUM_T));

   always_comb begin
      sc_op    = sc_op_sel(sc_clr, sc_ld, ld_ok, sc_inr, halt);
      sc_d     = sc_q;
      t_wrap_d = 1'b0;
      ld_err_d = ld_err_q;
      case (sc_op)
         SC_OP_CLR: sc_d = '0;
         SC_OP_LD:  sc_d = sc_ld_val;
         SC_OP_INR: begin
            // Explicit wrap so non-power-of-two NUM_T never reaches an unused code.
            sc_d     = at_last ? '0 : sc_q + SC_W'(1);
            t_wrap_d = at_last;
         end
         default: begin
            if (sc_ld && !sc_clr)
               ld_err_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sc_q     <= '0;
         t_wrap_q <= 1'b0;
         ld_err_q <= 1'b0;
      end else begin
         sc_q     <= sc_d;
         t_wrap_q <= t_wrap_d;
         ld_err_q <= ld_err_d;
      end
   end

   onehot_decoder #(
      .IN_W  (SC_W),
      .OUT_N (NUM_T)
   ) u_t_dec (
      .in_dat  (sc_q),
      .out_dat (t)
   );

   assign sc     = sc_q;
   assign t_last = at_last;
   assign t_wrap = t_wrap_q;
   assign ld_err = ld_err_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Scoreboard bench: three sequencers (NUM_T = 16, 10, 5) share control stimulus against a queue-fed model.
module tb_timing_sequencer;

   typedef struct {
      int sc;
      int wrap;
      int err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sc_clr = 1'b0, sc_ld = 1'b0, sc_inr = 1'b0, halt = 1'b0;
   logic [3:0] ld_val16 = '0, ld_val10 = '0;
   logic [2:0] ld_val5 = '0;

   logic [3:0]  sc16, sc10;
   logic [2:0]  sc5;
   logic [15:0] t16;
   logic [9:0]  t10;
   logic [4:0]  t5;
   logic last16, last10, last5, wrap16, wrap10, wrap5, err16, err10, err5;

   int n_tests = 0;
   int n_fail  = 0;
   bit run = 1'b0;

   int   nt [3] = '{16, 10, 5};
   int   m_sc [3];
   int   m_wrap [3];
   int   m_err [3];
   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];

   always #5 clk = ~clk;

   timing_sequencer #(.NUM_T(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .sc_clr(sc_clr), .sc_ld(sc_ld), .sc_ld_val(ld_val16),
      .sc_inr(sc_inr), .halt(halt), .sc(sc16), .t(t16), .t_last(last16),
      .t_wrap(wrap16), .ld_err(err16));

   timing_sequencer #(.NUM_T(10)) u_dut10 (
      .clk(clk), .rst_n(rst_n), .sc_clr(sc_clr), .sc_ld(sc_ld), .sc_ld_val(ld_val10),
      .sc_inr(sc_inr), .halt(halt), .sc(sc10), .t(t10), .t_last(last10),
      .t_wrap(wrap10), .ld_err(err10));

   timing_sequencer #(.NUM_T(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .sc_clr(sc_clr), .sc_ld(sc_ld), .sc_ld_val(ld_val5),
      .sc_inr(sc_inr), .halt(halt), .sc(sc5), .t(t5), .t_last(last5),
      .t_wrap(wrap5), .ld_err(err5));

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic void push_all();
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         e.sc = m_sc[k]; e.wrap = m_wrap[k]; e.err = m_err[k];
         case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         m_sc[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
      end
   endfunction

   // Reference behaviour: what the counter should show after the coming edge.
   function automatic void model_edge(input bit clr, input bit ld, input int val, input bit inr, input bit hlt);
      int v;
      for (int k = 0; k < 3; k++) begin
         v = (k == 2) ? (val % 8) : (val % 16);
         m_wrap[k] = 0;
         if (clr) begin
            m_sc[k] = 0;
         end else if (ld) begin
            if (v < nt[k]) m_sc[k] = v;
            else m_err[k] = 1;
         end else if (inr && !hlt) begin
            if (m_sc[k] == nt[k] - 1) begin
               m_sc[k] = 0;
               m_wrap[k] = 1;
            end else begin
               m_sc[k] = m_sc[k] + 1;
            end
         end
      end
   endfunction

   task automatic reset_cycle();
      @(negedge clk);
      rst_n = 1'b0;
      sc_clr = 0; sc_ld = 0; sc_inr = 0; halt = 0;
      model_reset();
      push_all();
      run = 1'b1;
   endtask

   task automatic step(input bit clr, input bit ld, input int val, input bit inr, input bit hlt);
      @(negedge clk);
      rst_n = 1'b1;
      sc_clr = clr; sc_ld = ld; sc_inr = inr; halt = hlt;
      ld_val16 = 4'(val); ld_val10 = 4'(val); ld_val5 = 3'(val);
      model_edge(clr, ld, val, inr, hlt);
      push_all();
   endtask

   task automatic compare_inst(input int k, input int sc_a, input int t_a, input int last_a,
                               input int wrap_a, input int err_a, input int oh_a);
      exp_t e;
      string p;
      p = $sformatf("n%0d", nt[k]);
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0) || (k == 2 && q2.size() == 0)) begin
         check({p, "_queue_empty"}, 1, 0);
         return;
      end
      case (k)
         0: e = q0.pop_front();
         1: e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
      check({p, "_sc"}, sc_a, e.sc);
      check({p, "_t"}, t_a, 1 << e.sc);
      check({p, "_t_last"}, last_a, (e.sc == nt[k] - 1) ? 1 : 0);
      check({p, "_t_wrap"}, wrap_a, e.wrap);
      check({p, "_ld_err"}, err_a, e.err);
      check({p, "_onehot"}, oh_a, 1);
   endtask

   always @(posedge clk) begin
      #1;
      if (run) begin
         compare_inst(0, int'(sc16), int'(t16), int'(last16), int'(wrap16), int'(err16), int'($onehot(t16)));
         compare_inst(1, int'(sc10), int'(t10), int'(last10), int'(wrap10), int'(err10), int'($onehot(t10)));
         compare_inst(2, int'(sc5),  int'(t5),  int'(last5),  int'(wrap5),  int'(err5),  int'($onehot(t5)));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      reset_cycle();
      reset_cycle();
      // Count through a full 16-state sequence, including the wrap.
      for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      // Priority: clear beats load and increment.
      step(0, 1, 5, 0, 0);
      step(1, 1, 9, 1, 0);
      // Halt freezes increment but not load.
      step(0, 1, 3, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
      step(0, 1, 7, 0, 1);
      // Illegal load on the 10-state counter must not increment; clear keeps ld_err.
      step(0, 1, 4, 0, 0);
      step(0, 1, 12, 1, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      // Asynchronous reset between edges.
      step(0, 1, 6, 0, 0);
      @(negedge clk);
      rst_n = 1'b1; sc_clr = 0; sc_ld = 0; sc_inr = 0; halt = 0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_sc16", int'(sc16), 0);
      check("async_t16", int'(t16), 1);
      check("async_sc10", int'(sc10), 0);
      check("async_err10", int'(err10), 0);
      check("async_t5", int'(t5), 1);
      model_reset();
      push_all();
      // Continuous increment across several wraps of every counter.
      for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 0);
      // Randomised control mix.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
      end
      @(posedge clk);
      #2;
      check("queue_drained", q0.size() + q1.size() + q2.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
